// File: rtl/block_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : block_mem_responder_pkg
// Brief    : Shared widths, defaults and FSM state encoding for the responder.
// Revision : 1.0 - initial release
// ============================================================================
package block_mem_responder_pkg;

    localparam int LINE_WIDTH          = 128;
    localparam int ADDR_WIDTH          = 28;
    localparam int LATENCY_DEFAULT     = 8;
    localparam int DEPTH_LINES_DEFAULT = 256;
    localparam int CNT_WIDTH           = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/block_mem_responder_line_ram.sv
`default_nettype none
// ============================================================================
// Module   : line_ram
// Brief    : Single-port line storage, synchronous write, combinational read.
// Revision : 1.0 - initial release
// ============================================================================
module line_ram
    import block_mem_responder_pkg::*;
#(
    parameter int WIDTH = LINE_WIDTH,
    parameter int DEPTH = DEPTH_LINES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/block_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : block_mem_responder
// Brief    : Fixed-latency line memory responder with abort and protocol checks.
// Revision : 1.0 - initial release
// ============================================================================
module block_mem_responder
    import block_mem_responder_pkg::*;
#(
    parameter int LATENCY     = LATENCY_DEFAULT,
    parameter int DEPTH_LINES = DEPTH_LINES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic                  mem_ready,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int                   c_IDX_W  = $clog2(DEPTH_LINES);
    localparam logic [CNT_WIDTH-1:0] c_LAT_M1 = CNT_WIDTH'(LATENCY - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  w_next_count;
    logic [c_IDX_W-1:0]    r_idx;
    logic                  r_write;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_mem_ready;
    logic                  r_proto_err;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_ram_we;
    logic [LINE_WIDTH-1:0] w_ram_rdata;
    logic                  w_unused_addr;

    // Address bits above the index are aliased away.
    assign w_unused_addr = ^mem_addr[ADDR_WIDTH-1:c_IDX_W];

    // The counter is loaded with LATENCY-1 and RESP is entered as it reaches
    // zero, so WAIT lasts LATENCY-1 cycles and mem_ready lands LATENCY cycles
    // after the accept cycle.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept     = 1'b1;
                    w_next_count = c_LAT_M1;
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!(mem_read || mem_write)) begin
                    w_abort      = 1'b1;
                    w_next_count = '0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_count = r_count - 1'b1;
                    if (r_count <= CNT_WIDTH'(1)) begin
                        w_next_state = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_write     <= 1'b0;
            r_wdata     <= '0;
            r_mem_ready <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_next_count;
            r_mem_ready <= (w_next_state == ST_RESP);
            if (w_accept) begin
                r_idx   <= mem_addr[c_IDX_W-1:0];
                r_write <= mem_write;
                r_wdata <= mem_wdata;
            end
            if ((w_accept && mem_read && mem_write) || w_abort) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // A reset landing on the RESP cycle must not commit the write.
    assign w_ram_we = (r_state == ST_RESP) && r_write && !rst;

    line_ram #(
        .WIDTH (LINE_WIDTH),
        .DEPTH (DEPTH_LINES)
    ) u_line_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign mem_ready = r_mem_ready;
    assign mem_rdata = (r_state == ST_RESP && !r_write) ? w_ram_rdata : '0;
    assign busy      = (r_state != ST_IDLE);
    assign proto_err = r_proto_err;

endmodule
`default_nettype wire

// File: doc/block_mem_responder.md
BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 8, meaning cycles from request acceptance to mem_ready (legal range 1..255).
REQ-002 The block SHALL have parameter DEPTH_LINES, default 256, meaning number of 128-bit lines stored (power of two, minimum 2).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 The block SHALL have port mem_read, input, 1, line read request, held by requester until mem_ready.
REQ-006 The block SHALL have port mem_write, input, 1, line write request, held by requester until mem_ready.
REQ-007 The block SHALL have port mem_addr, input, 28, line address; low log2(DEPTH_LINES) bits index storage, upper bits ignored.
REQ-008 The block SHALL have port mem_wdata, input, 128, write line data.
REQ-009 The block SHALL have port mem_ready, output, 1, single-cycle completion pulse.
REQ-010 The block SHALL have port mem_rdata, output, 128, read line data, valid only while mem_ready=1.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 The block SHALL have port proto_err, output, 1, sticky flag for protocol violations.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, mem_read|mem_write high SHALL accept the request: latch addr, op, wdata; load counter LATENCY-1; go to WAIT, or go directly to RESP if LATENCY=1.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at count 0 the next state SHALL be RESP.
REQ-016 mem_ready SHALL be registered, high exactly in the RESP cycle, i.e. LATENCY cycles after the accept edge; RESP SHALL always return to IDLE.
REQ-017 For reads, mem_rdata SHALL equal storage[latched index] during RESP, and 0 in every other cycle.
REQ-018 For writes, storage SHALL be updated with latched wdata at the end of the RESP cycle; mem_rdata SHALL stay 0.
REQ-019 A new request SHALL be acceptable in the cycle immediately after RESP (back-to-back throughput = one line per LATENCY+1 cycles).
REQ-020 Changes to mem_addr/mem_wdata after acceptance SHALL be ignored; the latched values govern.
REQ-021 If mem_read and mem_write are both high at acceptance, the request SHALL be processed as a write and proto_err SHALL set.
REQ-022 If both mem_read and mem_write drop during WAIT, the request SHALL abort: return to IDLE next cycle, no mem_ready, no storage write, proto_err set.
REQ-023 A read following a write to the same index SHALL return the newly written data.
REQ-024 Index arithmetic SHALL wrap: addresses differing only above the index bits SHALL alias to the same line.

Reset
REQ-025 On rst: state IDLE, counter 0, mem_ready 0, mem_rdata 0, busy 0, proto_err 0, latched registers 0.
REQ-026 rst asserted mid-WAIT or in RESP SHALL cancel the transaction: no mem_ready pulse after reset, and no storage write.
REQ-027 Storage contents SHALL NOT be cleared by rst; power-up contents are undefined.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, LINE_WIDTH=128, ADDR_WIDTH=28, and the LATENCY/DEPTH defaults.
REQ-029 Storage SHALL be a sub-module line_ram: single port, synchronous write, 128-bit, DEPTH_LINES entries, combinational read.

Verification
REQ-030 LATENCY=8: write 0xA5..A5 to addr 0x10, accept at cycle T -> mem_ready high only at T+8; then read 0x10 -> mem_rdata=0xA5..A5 at accept+8.
REQ-031 LATENCY=1: read accepted at T -> mem_ready at T+1; a new request at T+2 is accepted, and its mem_ready arrives at T+3.
REQ-032 Read accepted, then mem_addr changes to 0x20 during WAIT -> data returned is from the originally latched address.
REQ-033 mem_read dropped at WAIT cycle 3 -> no mem_ready, busy low the next cycle, proto_err=1; storage unchanged.
REQ-034 rst pulsed mid-write -> mem_ready stays 0 and target line retains its old value; proto_err=0.
REQ-035 DEPTH_LINES=256: write addr 0x005, read addr 0x105 -> same data (alias); mem_read+mem_write together -> write performed, proto_err=1.
